// File: rtl/harness_byte_framer_pkg.sv
// Types and helpers shared by the framer top and its word FIFO.
package harness_byte_framer_pkg;
`include "harness_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE = `HBF_ST_IDLE,
    ST_SYNC = `HBF_ST_SYNC,
    ST_DATA = `HBF_ST_DATA
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = `HBF_SYNC_BYTE;

  function automatic int bcnt_w(input int word_w);
    return `HBF_BCNT_W(word_w);
  endfunction

endpackage

// File: rtl/harness_defs.vh
// Shared encodings and width derivations for the harness byte framer.
`ifndef HARNESS_DEFS_VH
`define HARNESS_DEFS_VH

`define HBF_ST_IDLE   2'd0
`define HBF_ST_SYNC   2'd1
`define HBF_ST_DATA   2'd2

`define HBF_SYNC_BYTE 8'hA5

// Data-byte index width; a single-byte word still needs one bit.
`define HBF_BCNT_W(word_w) ((((word_w) / 8) > 1) ? $clog2((word_w) / 8) : 1)

`endif

// File: rtl/harness_word_fifo.sv
// First-word fall-through word FIFO; a read frees its slot for a write on the same edge.
module harness_word_fifo #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK_48MHZ,
  input  logic              RESET_N,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][WORD_W-1:0] mem;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_wr, do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);

  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/harness_byte_framer.sv
// Buffers tapped words and replays each as a sync byte plus MSB-first data bytes,
// every byte held HOLD_CYCLES clocks with a sample clock rising mid-byte.
module harness_byte_framer
  import harness_byte_framer_pkg::*;
#(
  parameter int         WORD_W      = 32,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         HOLD_CYCLES = 48,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE
) (
  input  logic              CLK_48MHZ,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic [WORD_W-1:0] TAP_DATA,
  input  logic              TAP_VALID,
  output logic [7:0]        BYTE_OUT,
  output logic              BYTE_CLK,
  output logic              FRAME_START,
  output logic              BUSY,
  output logic              OVERFLOW,
  output logic [7:0]        DROP_CNT
);
  localparam int NBYTES = WORD_W / 8;
  localparam int BCNT_W = bcnt_w(WORD_W);
  localparam int HCNT_W = $clog2(HOLD_CYCLES);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HALF_M1   = HCNT_W'(HOLD_CYCLES / 2 - 1);
  localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(NBYTES - 1);

  state_t              state;
  logic [HCNT_W-1:0]   hold_cnt;
  logic [BCNT_W-1:0]   byte_idx;
  logic [WORD_W-1:0]   shreg, sh_next, rd_data;
  logic                full, empty, wrap, last, pop, cap, wr_en, drop;

  assign wrap    = (hold_cnt == HOLD_LAST);
  assign last    = (byte_idx == BYTE_LAST);
  assign sh_next = shreg << 8;
  assign pop     = !empty && ((state == ST_IDLE) || (state == ST_DATA && wrap && last));

  // A pop on the same edge frees a slot, so a full FIFO still takes the word.
  assign cap   = TAP_VALID && ENABLE;
  assign wr_en = cap && (!full || pop);
  assign drop  = cap && full && !pop;

  harness_word_fifo #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK_48MHZ (CLK_48MHZ),
    .RESET_N   (RESET_N),
    .wr_en     (wr_en),
    .wr_data   (TAP_DATA),
    .rd_en     (pop),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      OVERFLOW <= 1'b0;
      DROP_CNT <= '0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
      if (DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
    end
  end

  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      byte_idx    <= '0;
      shreg       <= '0;
      BYTE_OUT    <= '0;
      BYTE_CLK    <= 1'b0;
      FRAME_START <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      FRAME_START <= 1'b0;
      case (state)
        ST_IDLE: begin
          BYTE_OUT <= '0;
          BYTE_CLK <= 1'b0;
          hold_cnt <= '0;
          if (!empty) begin
            shreg       <= rd_data;
            state       <= ST_SYNC;
            BYTE_OUT    <= SYNC_BYTE;
            FRAME_START <= 1'b1;
            BUSY        <= 1'b1;
          end
        end
        default: begin
          if (!wrap) begin
            hold_cnt <= hold_cnt + 1'b1;
            // Registered, so decide from the count about to be entered.
            BYTE_CLK <= (hold_cnt >= HALF_M1);
          end else begin
            hold_cnt <= '0;
            BYTE_CLK <= 1'b0;
            if (state == ST_SYNC) begin
              state    <= ST_DATA;
              byte_idx <= '0;
              BYTE_OUT <= shreg[WORD_W-1 -: 8];
            end else if (!last) begin
              shreg    <= sh_next;
              byte_idx <= byte_idx + 1'b1;
              BYTE_OUT <= sh_next[WORD_W-1 -: 8];
            end else if (!empty) begin
              shreg       <= rd_data;
              state       <= ST_SYNC;
              BYTE_OUT    <= SYNC_BYTE;
              FRAME_START <= 1'b1;
            end else begin
              state    <= ST_IDLE;
              BYTE_OUT <= '0;
              BUSY     <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harness_byte_framer.sv
// Directed stimulus with a byte scoreboard checked by an independent negedge monitor.
module tb_harness_byte_framer;
  localparam int WORD_W = 32;
  localparam int HOLD   = 4;

  logic        CLK_48MHZ = 1'b0;
  logic        RESET_N   = 1'b0;
  logic        ENABLE    = 1'b0;
  logic        TAP_VALID = 1'b0;
  logic [31:0] TAP_DATA  = '0;
  logic [7:0]  BYTE_OUT, DROP_CNT;
  logic        BYTE_CLK, FRAME_START, BUSY, OVERFLOW;

  harness_byte_framer #(
    .WORD_W      (WORD_W),
    .FIFO_DEPTH  (4),
    .HOLD_CYCLES (HOLD),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .CLK_48MHZ   (CLK_48MHZ),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
    .TAP_DATA    (TAP_DATA),
    .TAP_VALID   (TAP_VALID),
    .BYTE_OUT    (BYTE_OUT),
    .BYTE_CLK    (BYTE_CLK),
    .FRAME_START (FRAME_START),
    .BUSY        (BUSY),
    .OVERFLOW    (OVERFLOW),
    .DROP_CNT    (DROP_CNT)
  );

  always #5 CLK_48MHZ = ~CLK_48MHZ;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] exp_q[$];
  int         fs_q[$];

  always @(posedge CLK_48MHZ) cyc++;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: each BYTE_CLK rise consumes one expected byte; the byte must hold while high.
  logic       prev_clk = 1'b0;
  logic       prev_fs  = 1'b0;
  logic [7:0] cur_exp  = '0;
  int         hi_run   = 0;

  always @(negedge CLK_48MHZ) begin
    if (!RESET_N) begin
      prev_clk = 1'b0;
      prev_fs  = 1'b0;
      hi_run   = 0;
    end else begin
      if (FRAME_START) begin
        check("fs_byte", {24'h0, BYTE_OUT}, 32'hA5);
        check("fs_width", {31'h0, prev_fs}, 32'h0);
        fs_q.push_back(cyc);
      end
      if (BYTE_CLK && !prev_clk) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", BYTE_OUT, $time);
          cur_exp = BYTE_OUT;
        end else begin
          cur_exp = exp_q.pop_front();
          check("byte", {24'h0, BYTE_OUT}, {24'h0, cur_exp});
        end
        hi_run = 1;
      end else if (BYTE_CLK) begin
        hi_run++;
        check("byte_hold", {24'h0, BYTE_OUT}, {24'h0, cur_exp});
      end else if (prev_clk) begin
        check("clk_high_len", hi_run, HOLD / 2);
      end
      prev_clk = BYTE_CLK;
      prev_fs  = FRAME_START;
    end
  end

  task automatic push_frame(input logic [31:0] w);
    exp_q.push_back(8'hA5);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge CLK_48MHZ);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    TAP_DATA  = w;
    TAP_VALID = 1'b1;
    @(posedge CLK_48MHZ);
    #1;
    TAP_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (BUSY && n < lim) begin
      @(posedge CLK_48MHZ);
      #1;
      n++;
    end
    check("idle_timeout", {31'h0, BUSY}, 32'h0);
    check("drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_out"}, {24'h0, BYTE_OUT}, 32'h0);
    check({tag, "_byte_clk"}, {31'h0, BYTE_CLK}, 32'h0);
    check({tag, "_frame_start"}, {31'h0, FRAME_START}, 32'h0);
    check({tag, "_busy"}, {31'h0, BUSY}, 32'h0);
    check({tag, "_overflow"}, {31'h0, OVERFLOW}, 32'h0);
    check({tag, "_drop_cnt"}, {24'h0, DROP_CNT}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] six_words [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                 32'h44444444, 32'h55555555, 32'h66666666};

  initial begin
    int n0;
    #1;
    check_reset_vals("rst0");
    wait_edges(2);
    RESET_N = 1'b1;
    ENABLE  = 1'b1;
    wait_edges(2);

    // Single word: latency, hold length, return to idle.
    push_frame(32'h12345678);
    send_word(32'h12345678);
    check("t1_busy_k", {31'h0, BUSY}, 32'h0);
    wait_edges(1);
    check("t1_fs_k1", {31'h0, FRAME_START}, 32'h1);
    check("t1_sync_k1", {24'h0, BYTE_OUT}, 32'hA5);
    wait_edges(1);
    check("t1_fs_k2", {31'h0, FRAME_START}, 32'h0);
    check("t1_bclk_cnt1", {31'h0, BYTE_CLK}, 32'h0);
    wait_edges(1);
    check("t1_bclk_cnt2", {31'h0, BYTE_CLK}, 32'h1);
    wait_edges(17);
    check("t1_busy_k20", {31'h0, BUSY}, 32'h1);
    check("t1_last_k20", {24'h0, BYTE_OUT}, 32'h78);
    wait_edges(1);
    check("t1_busy_k21", {31'h0, BUSY}, 32'h0);
    check("t1_out_k21", {24'h0, BYTE_OUT}, 32'h0);

    // Back-to-back frames.
    n0 = fs_q.size();
    push_frame(32'hDEADBEEF);
    push_frame(32'h00FF00FF);
    TAP_DATA  = 32'hDEADBEEF;
    TAP_VALID = 1'b1;
    wait_edges(1);
    TAP_DATA  = 32'h00FF00FF;
    wait_edges(1);
    TAP_VALID = 1'b0;
    wait_idle(100);
    check("t2_fs_count", fs_q.size() - n0, 2);
    if (fs_q.size() >= n0 + 2) check("t2_fs_gap", fs_q[n0+1] - fs_q[n0], 20);

    // Six words into a depth-4 FIFO: one drop.
    for (int i = 0; i < 5; i++) push_frame(six_words[i]);
    for (int i = 0; i < 6; i++) begin
      TAP_DATA  = six_words[i];
      TAP_VALID = 1'b1;
      wait_edges(1);
      if (i == 4) begin
        check("t3_ovf_k4", {31'h0, OVERFLOW}, 32'h0);
        check("t3_drop_k4", {24'h0, DROP_CNT}, 32'h0);
      end
      if (i == 5) begin
        check("t3_ovf_k5", {31'h0, OVERFLOW}, 32'h1);
        check("t3_drop_k5", {24'h0, DROP_CNT}, 32'h1);
      end
    end
    TAP_VALID = 1'b0;
    wait_idle(300);

    // 300 consecutive words: 5 accepted up front, then one per frame end (14), rest dropped.
    for (int i = 0; i < 19; i++) push_frame(32'hC3C3C3C3);
    TAP_DATA  = 32'hC3C3C3C3;
    TAP_VALID = 1'b1;
    repeat (300) @(posedge CLK_48MHZ);
    #1;
    TAP_VALID = 1'b0;
    check("t4_drop_sat", {24'h0, DROP_CNT}, 32'hFF);
    check("t4_ovf", {31'h0, OVERFLOW}, 32'h1);
    wait_idle(1000);
    check("t4_drop_stays", {24'h0, DROP_CNT}, 32'hFF);
    check("t4_ovf_stays", {31'h0, OVERFLOW}, 32'h1);

    // Reset clears sticky state; ENABLE=0 ignores valid words.
    RESET_N = 1'b0;
    #1;
    check_reset_vals("rst1");
    wait_edges(1);
    RESET_N = 1'b1;
    ENABLE  = 1'b0;
    for (int i = 0; i < 6; i++) send_word(32'h0A0B0C0D);
    wait_edges(2);
    check("t5_busy", {31'h0, BUSY}, 32'h0);
    check("t5_drop", {24'h0, DROP_CNT}, 32'h0);
    check("t5_ovf", {31'h0, OVERFLOW}, 32'h0);
    ENABLE = 1'b1;
    push_frame(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    wait_edges(6);
    ENABLE = 1'b0;
    send_word(32'h0BADBEEF);
    wait_idle(100);
    check("t5_drop_after", {24'h0, DROP_CNT}, 32'h0);

    // Async reset during the second data byte.
    ENABLE = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h11);
    send_word(32'h11223344);
    wait_edges(9);
    check("t6_byte2", {24'h0, BYTE_OUT}, 32'h22);
    #2;
    RESET_N = 1'b0;
    #1;
    check_reset_vals("rst2");
    check("t6_partial_seen", exp_q.size(), 0);
    wait_edges(1);
    RESET_N = 1'b1;
    wait_edges(1);
    push_frame(32'h55667788);
    send_word(32'h55667788);
    wait_edges(1);
    check("t6_fs_after", {31'h0, FRAME_START}, 32'h1);
    check("t6_sync_after", {24'h0, BYTE_OUT}, 32'hA5);
    wait_idle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
